sd_block_reader: RTL and testbench



---
 rtl/sd_block_reader.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// sd_block_reader: single-block SD read in SPI mode. Sends CMD17, collects R1, waits for the
// 0xFE start token, streams DATA_NUM 16-bit words (MSB first), skips the CRC, releases cs_n.
module sd_block_reader #(
  parameter int unsigned DATA_NUM      = 256,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY     = 8,
  parameter int unsigned TOKEN_TIMEOUT = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        miso,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic        cs_n,
  output logic        mosi,
  output logic        rd_busy,
  output logic [15:0] rd_data,
  output logic        rd_data_en,
  output logic        rd_done,
  output logic        rd_err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SEND_CMD   = 3'd1;
  localparam logic [2:0] CMD_ACK    = 3'd2;
  localparam logic [2:0] WAIT_TOKEN = 3'd3;
  localparam logic [2:0] RD_DATA    = 3'd4;
  localparam logic [2:0] CRC        = 3'd5;
  localparam logic [2:0] END_WAIT   = 3'd6;

  localparam logic [7:0]  AckLast  = 8'(ACK_TIMEOUT - 1);
  localparam logic [15:0] TokLast  = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRY);
  localparam logic [8:0]  WordLast = 9'(DATA_NUM - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;          // shared bit counter: cmd, R1, data bits, CRC, END
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic [15:0] tok_cnt_q, tok_cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [8:0]  word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  win_q, win_d;
  logic        r1_act_q, r1_act_d;    // start bit seen, collecting the rest of R1
  logic        err_q, err_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_data_en_q, rd_data_en_d;
  logic        rd_done_q, rd_done_d;
  logic        rd_err_q, rd_err_d;

  logic [47:0] cmd;
  logic [15:0] shift_in;
  logic [7:0]  r1_full;
  logic [7:0]  win_in;
  logic [3:0]  retry_inc;
  logic        ack_fail;

  assign cmd       = {8'h51, addr_q, 8'hFF};
  assign shift_in  = {shift_q[14:0], miso};
  assign r1_full   = {shift_q[6:0], miso};
  assign win_in    = {win_q[6:0], miso};
  assign retry_inc = retry_q + 4'd1;

  // Next-state and registered-output logic for the whole read sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_cnt_d    = ack_cnt_q;
    tok_cnt_d    = tok_cnt_q;
    retry_d      = retry_q;
    word_d       = word_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    win_d        = win_q;
    r1_act_d     = r1_act_q;
    err_d        = err_q;
    cs_n_d       = cs_n_q;
    mosi_d       = 1'b1;
    rd_data_d    = rd_data_q;
    rd_data_en_d = 1'b0;
    rd_done_d    = 1'b0;
    rd_err_d     = 1'b0;
    ack_fail     = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (rd_en) begin
          addr_d    = rd_addr;
          retry_d   = 4'd0;
          err_d     = 1'b0;
          cnt_d     = 6'd0;
          ack_cnt_d = 8'd0;
          cs_n_d    = 1'b0;
          state_d   = SEND_CMD;
        end
      end

      SEND_CMD: begin
        mosi_d = cmd[6'd47 - cnt_q];
        if (cnt_q == 6'd47) begin
          cnt_d     = 6'd0;
          ack_cnt_d = 8'd0;
          r1_act_d  = 1'b0;
          state_d   = CMD_ACK;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      CMD_ACK: begin
        if (r1_act_q) begin
          shift_d = shift_in;
          if (cnt_q == 6'd6) begin
            r1_act_d = 1'b0;
            if (r1_full == 8'h00) begin
              tok_cnt_d = 16'd0;
              win_d     = 8'h00;
              state_d   = WAIT_TOKEN;
            end else begin
              ack_fail = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else if (!miso) begin
          // Start bit wins even on the cycle the timeout would expire.
          r1_act_d = 1'b1;
          cnt_d    = 6'd0;
          shift_d  = shift_in;
        end else if (ack_cnt_q == AckLast) begin
          ack_fail = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end

        if (ack_fail) begin
          retry_d   = retry_inc;
          cnt_d     = 6'd0;
          ack_cnt_d = 8'd0;
          if (retry_inc == RetryMax) begin
            err_d   = 1'b1;
            state_d = END_WAIT;
          end else begin
            state_d = SEND_CMD;
          end
        end
      end

      WAIT_TOKEN: begin
        win_d = win_in;
        if (win_in == 8'hFE) begin
          cnt_d   = 6'd0;
          word_d  = 9'd0;
          state_d = RD_DATA;
        end else if (tok_cnt_q == TokLast) begin
          err_d   = 1'b1;
          cnt_d   = 6'd0;
          state_d = END_WAIT;
        end else begin
          tok_cnt_d = tok_cnt_q + 16'd1;
        end
      end

      RD_DATA: begin
        shift_d = shift_in;
        if (cnt_q == 6'd15) begin
          rd_data_d    = shift_in;
          rd_data_en_d = 1'b1;
          cnt_d        = 6'd0;
          if (word_q == WordLast) begin
            state_d = CRC;
          end else begin
            word_d = word_q + 9'd1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      CRC: begin
        if (cnt_q == 6'd15) begin
          cnt_d   = 6'd0;
          state_d = END_WAIT;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      END_WAIT: begin
        if (cnt_q == 6'd7) begin
          cnt_d     = 6'd0;
          cs_n_d    = 1'b1;
          rd_done_d = ~err_q;
          rd_err_d  = err_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      default: begin
        cs_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset returns everything to idle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      ack_cnt_q    <= 8'd0;
      tok_cnt_q    <= 16'd0;
      retry_q      <= 4'd0;
      word_q       <= 9'd0;
      addr_q       <= 32'd0;
      shift_q      <= 16'd0;
      win_q        <= 8'd0;
      r1_act_q     <= 1'b0;
      err_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b1;
      rd_data_q    <= 16'd0;
      rd_data_en_q <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      tok_cnt_q    <= tok_cnt_d;
      retry_q      <= retry_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      win_q        <= win_d;
      r1_act_q     <= r1_act_d;
      err_q        <= err_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      rd_data_q    <= rd_data_d;
      rd_data_en_q <= rd_data_en_d;
      rd_done_q    <= rd_done_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign rd_busy    = (state_q != IDLE);
  assign rd_data    = rd_data_q;
  assign rd_data_en = rd_data_en_q;
  assign rd_done    = rd_done_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: a scripted SD card drives miso, a bit-stream model predicts
// every strobe and the end pulse, and directed reads cover the main and corner cases.
module tb_sd_block_reader;

  localparam int SC_DATA    = 0;
  localparam int SC_BADR1   = 1;
  localparam int SC_SILENT  = 2;
  localparam int SC_NOTOKEN = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        miso    = 1'b1;
  logic        rd_en   = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        cs_n, mosi, rd_busy, rd_data_en, rd_done, rd_err;
  logic [15:0] rd_data;

  sd_block_reader dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .miso      (miso),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .rd_data_en(rd_data_en),
    .rd_done   (rd_done),
    .rd_err    (rd_err)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_strobe = 0;
  logic [15:0] last_rd = 16'h0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- card + reference model ----------------
  typedef struct {
    int          c;
    logic [15:0] d;
  } ev_t;

  int          scen = SC_DATA;
  int          idle_ones = 24;
  logic [15:0] pat_xor = 16'h0;
  logic [15:0] pat_mul = 16'h1;
  bit          resp[$];
  ev_t         exp_q[$];
  logic [47:0] frames[$];
  int          frame_c[$];
  int          exp_done_c = -1;
  int          exp_err_c = -1;
  int          model_first_c = -1;
  logic        collecting = 1'b0;
  logic [47:0] frame_sh = 48'h0;
  int          frame_bits = 0;

  function automatic logic [15:0] word_val(input int w);
    return pat_xor ^ (16'(w) * pat_mul);
  endfunction

  task automatic push_bits(input logic [15:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) resp.push_back(v[i]);
  endtask

  // Response bit i goes on miso after edge f+i and is sampled at edge f+1+i.
  task automatic build_response(input int f);
    int n;
    n = frames.size();
    resp.delete();
    if (scen == SC_SILENT) begin
      if (n == 8) exp_err_c = f + 255 + 8;
      return;
    end
    repeat (idle_ones) resp.push_back(1'b1);
    if (scen == SC_BADR1 && n <= 2) begin
      push_bits(16'h0004, 8);
      return;
    end
    push_bits(16'h0000, 8);
    if (scen == SC_NOTOKEN) begin
      exp_err_c = f + resp.size() + 65535 + 8;
      return;
    end
    repeat (20) resp.push_back(1'b1);
    push_bits(16'h00FE, 8);
    for (int w = 0; w < 256; w++) begin
      push_bits(word_val(w), 16);
      exp_q.push_back('{c: f + resp.size(), d: word_val(w)});
      if (w == 0) model_first_c = f + resp.size();
    end
    exp_done_c = f + resp.size() + 16 + 8;
    push_bits(16'h3C5A, 16);
  endtask

  // Card: decode CMD frames on mosi, then play the scripted response on miso.
  always @(posedge sys_clk) begin
    #1;
    if (sys_rst) begin
      collecting = 1'b0;
      miso = 1'b1;
    end else begin
      if (!cs_n) begin
        if (collecting) begin
          frame_sh = {frame_sh[46:0], mosi};
          frame_bits++;
          if (frame_bits == 48) begin
            collecting = 1'b0;
            frames.push_back(frame_sh);
            frame_c.push_back(cyc);
            build_response(cyc);
          end
        end else if (mosi == 1'b0) begin
          collecting = 1'b1;
          frame_sh = {47'h0, mosi};
          frame_bits = 1;
        end
      end
      if (resp.size() > 0) miso = resp.pop_front();
      else miso = 1'b1;
    end
  end

  // Compare DUT strobes and end pulses against the model whenever either side is active.
  logic        ce_en;
  logic [15:0] ce_d;
  always @(posedge sys_clk) begin
    #2;
    if (!sys_rst) begin
      ce_en = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      ce_d  = ce_en ? exp_q[0].d : 16'h0;
      if (ce_en) exp_q.delete(0);
      if (ce_en || rd_data_en) begin
        chk("rd_data_en", rd_data_en, ce_en);
        if (ce_en) chk("rd_data", rd_data, ce_d);
      end
      if (rd_data_en) begin
        n_strobe++;
        last_rd = rd_data;
      end
      if (rd_done || cyc == exp_done_c) chk("rd_done", rd_done, cyc == exp_done_c);
      if (rd_err || cyc == exp_err_c) chk("rd_err", rd_err, cyc == exp_err_c);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setup(input int s, input int idle, input logic [15:0] px, input logic [15:0] pm);
    scen = s;
    idle_ones = idle;
    pat_xor = px;
    pat_mul = pm;
    frames.delete();
    frame_c.delete();
    exp_q.delete();
    exp_done_c = -1;
    exp_err_c = -1;
    model_first_c = -1;
  endtask

  task automatic start_read(input logic [31:0] a, output int t);
    @(negedge sys_clk);
    rd_en = 1'b1;
    rd_addr = a;
    @(posedge sys_clk);
    #1;
    t = cyc;
    chk("busy_after_accept", rd_busy, 1'b1);
    chk("cs_n_after_accept", cs_n, 1'b0);
    @(negedge sys_clk);
    rd_en = 1'b0;
    rd_addr = ~a;
  endtask

  task automatic wait_end(input int budget, output int c_end, output logic was_err);
    logic prev_cs;
    prev_cs = cs_n;
    c_end = -1;
    was_err = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #3;
      if (rd_done || rd_err) begin
        c_end = cyc;
        was_err = rd_err;
        chk("cs_n_high_at_end", cs_n, 1'b1);
        chk("busy_low_at_end", rd_busy, 1'b0);
        chk("cs_n_low_before_end", prev_cs, 1'b0);
        break;
      end
      prev_cs = cs_n;
    end
    chk("end_seen", c_end >= 0, 1'b1);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int i;
    i = 0;
    while (n_strobe < target && i < budget) begin
      @(posedge sys_clk);
      #3;
      i++;
    end
    chk("strobe_wait", n_strobe >= target, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1'b1);
    chk({tag, "_mosi"}, mosi, 1'b1);
    chk({tag, "_busy"}, rd_busy, 1'b0);
    chk({tag, "_rd_data"}, rd_data, 16'h0000);
    chk({tag, "_rd_data_en"}, rd_data_en, 1'b0);
    chk({tag, "_rd_done"}, rd_done, 1'b0);
    chk({tag, "_rd_err"}, rd_err, 1'b0);
  endtask

  initial begin
    #(20 * 98000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          t;
    int          c_end;
    int          s0;
    logic        was_err;
    logic [31:0] a;

    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Nominal read, plus an ignored rd_en with another address while busy.
    setup(SC_DATA, 24, 16'h0000, 16'h0001);
    s0 = n_strobe;
    start_read(32'h0000_1234, t);
    repeat (60) @(negedge sys_clk);
    chk("model_first_strobe_ofs", model_first_c - t, 124);
    chk("model_done_ofs", exp_done_c - t, 4228);
    repeat (140) @(negedge sys_clk);
    rd_en = 1'b1;
    rd_addr = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    rd_en = 1'b0;
    wait_end(5000, c_end, was_err);
    chk("nominal_is_done", was_err, 1'b0);
    chk("nominal_end_ofs", c_end - t, 4228);
    chk("nominal_strobes", n_strobe - s0, 256);
    chk("nominal_last_word", last_rd, 16'h00FF);
    repeat (60) @(negedge sys_clk);
    chk("nominal_frames", frames.size(), 1);
    if (frames.size() > 0) chk("nominal_frame", frames[0], 48'h51_0000_1234_FF);
    chk("idle_mosi", mosi, 1'b1);

    // Bad R1 twice, then a good block.
    setup(SC_BADR1, 8, 16'h5A3C, 16'h0101);
    s0 = n_strobe;
    a = 32'h00AB_CDEF;
    start_read(a, t);
    wait_end(6000, c_end, was_err);
    chk("badr1_is_done", was_err, 1'b0);
    chk("badr1_end_ofs", c_end - t, 4340);
    chk("badr1_strobes", n_strobe - s0, 256);
    chk("badr1_last_word", last_rd, 16'hA5C3);
    chk("badr1_frames", frames.size(), 3);
    for (int k = 0; k < frames.size(); k++) chk("badr1_frame", frames[k], {8'h51, a, 8'hFF});
    if (frame_c.size() > 2) chk("badr1_third_frame_ofs", frame_c[2] - t, 176);

    // Card never answers: eight attempts then rd_err.
    setup(SC_SILENT, 0, 16'h0, 16'h1);
    s0 = n_strobe;
    a = 32'h0000_0007;
    start_read(a, t);
    wait_end(3000, c_end, was_err);
    chk("silent_is_err", was_err, 1'b1);
    chk("silent_end_ofs", c_end - t, 2432);
    chk("silent_strobes", n_strobe - s0, 0);
    chk("silent_frames", frames.size(), 8);
    for (int k = 0; k < frame_c.size(); k++) begin
      chk("silent_frame_ofs", frame_c[k] - t, 48 + 303 * k);
      chk("silent_frame", frames[k], {8'h51, a, 8'hFF});
    end

    // Reset during word 100, then a read whose start bit lands on the last ack cycle.
    setup(SC_DATA, 24, 16'h1111, 16'h0003);
    s0 = n_strobe;
    start_read(32'h0000_0055, t);
    wait_strobes(s0 + 100, 2000);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    resp.delete();
    exp_q.delete();
    exp_done_c = -1;
    exp_err_c = -1;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("midreset_strobes", n_strobe - s0, 100);

    setup(SC_DATA, 254, 16'h0F0F, 16'h0101);
    s0 = n_strobe;
    a = 32'hCAFE_0001;
    start_read(a, t);
    wait_end(6000, c_end, was_err);
    chk("edge_ack_is_done", was_err, 1'b0);
    chk("edge_ack_end_ofs", c_end - t, 4458);
    chk("edge_ack_strobes", n_strobe - s0, 256);
    chk("edge_ack_frames", frames.size(), 1);
    if (frames.size() > 0) chk("edge_ack_frame", frames[0], {8'h51, a, 8'hFF});

    // R1 ok but no start token.
    setup(SC_NOTOKEN, 24, 16'h0, 16'h1);
    s0 = n_strobe;
    start_read(32'h0000_0099, t);
    wait_end(70000, c_end, was_err);
    chk("token_is_err", was_err, 1'b1);
    chk("token_end_ofs", c_end - t, 65623);
    chk("token_strobes", n_strobe - s0, 0);
    chk("token_frames", frames.size(), 1);

    repeat (4) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
